// File: rtl/store_module_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_module_pkg
// Purpose  : Shared widths, FSM state type and SEC-DED helpers for the store path.
// Revision : 1.0
// ============================================================================
package store_module_pkg;

    localparam int DATA_W   = 32;
    localparam int PARITY_W = 7;
    localparam int CODE_LEN = 38;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              single_err;
        logic              double_err;
    } decode_t;

    // Data bits sit at the non-power-of-two codeword positions 3..38 in order.
    function automatic logic [5:0] hamming_bits(input logic [DATA_W-1:0] d);
        logic [5:0] p;
        int         k;
        p = '0;
        k = 0;
        for (int pos = 1; pos <= CODE_LEN; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int i = 0; i < 6; i++) begin
                    if (pos[i]) begin
                        p[i] = p[i] ^ d[k];
                    end
                end
                k++;
            end
        end
        return p;
    endfunction

    function automatic decode_t secded_decode(input logic [DATA_W-1:0]   d,
                                              input logic [PARITY_W-1:0] p);
        decode_t    r;
        logic [5:0] syn;
        logic       overall;
        int         k;
        syn          = hamming_bits(d) ^ p[5:0];
        overall      = ^{d, p};
        r.data       = d;
        r.single_err = 1'b0;
        r.double_err = 1'b0;
        k            = 0;
        if (overall) begin
            // Odd weight: one flipped bit, unless the syndrome points past the codeword.
            if (int'(syn) > CODE_LEN) begin
                r.double_err = 1'b1;
            end else begin
                r.single_err = 1'b1;
                for (int pos = 1; pos <= CODE_LEN; pos++) begin
                    if ((pos & (pos - 1)) != 0) begin
                        if (pos == int'(syn)) begin
                            r.data[k] = ~r.data[k];
                        end
                        k++;
                    end
                end
            end
        end else if (syn != 6'd0) begin
            r.double_err = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_module_if.sv
`default_nettype none
// ============================================================================
// Module   : store_module_if
// Purpose  : Store request bus plus cache read/write port of the store path.
// Revision : 1.0
// ============================================================================
interface store_module_if
    import store_module_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic                st_valid;
    logic                st_ready;
    logic [ADDR_W-1:0]   st_addr;
    logic [DATA_W-1:0]   st_data;
    logic [3:0]          st_be;
    logic                st_done;
    logic                single_error;
    logic                DED_exception;
    logic                cache_rd_en;
    logic [ADDR_W-1:0]   cache_addr;
    logic [DATA_W-1:0]   cache_rd_data;
    logic [PARITY_W-1:0] cache_rd_parity;
    logic                cache_wr_en;
    logic [DATA_W-1:0]   cache_wr_data;
    logic [PARITY_W-1:0] cache_wr_parity;

    modport slave (
        input  st_valid, st_addr, st_data, st_be, cache_rd_data, cache_rd_parity,
        output st_ready, st_done, single_error, DED_exception,
               cache_rd_en, cache_addr, cache_wr_en, cache_wr_data, cache_wr_parity
    );

    modport master (
        output st_valid, st_addr, st_data, st_be, cache_rd_data, cache_rd_parity,
        input  st_ready, st_done, single_error, DED_exception,
               cache_rd_en, cache_addr, cache_wr_en, cache_wr_data, cache_wr_parity
    );
endinterface
`default_nettype wire

// File: rtl/store_module_secded_encode.sv
`default_nettype none
// ============================================================================
// Module   : secded_encode
// Purpose  : Hamming(38,32) check bits plus overall parity for one data word.
// Revision : 1.0
// ============================================================================
module secded_encode
    import store_module_pkg::*;
(
    input  wire logic [DATA_W-1:0]   data,
    output logic      [PARITY_W-1:0] parity
);
    logic [5:0] w_ham;

    assign w_ham  = hamming_bits(data);
    assign parity = {^{data, w_ham}, w_ham};
endmodule
`default_nettype wire

// File: rtl/store_module.sv
`default_nettype none
// ============================================================================
// Module   : store_module
// Purpose  : Byte-masked store into a SEC-DED protected cache via read-modify-write.
// Revision : 1.0
// ============================================================================
module store_module
    import store_module_pkg::*;
#(
    parameter int ADDR_W = 10
)(
    input wire logic       clk,
    input wire logic       rst_n,
    store_module_if.slave  bus
);
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_st_data;
    logic [3:0]          r_be;
    logic [DATA_W-1:0]   r_wr_data;
    logic [PARITY_W-1:0] r_wr_parity;
    logic                r_rd_en;
    logic                r_wr_en;
    logic                r_done;

    decode_t             w_dec;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_enc_in;
    logic [PARITY_W-1:0] w_enc_parity;
    logic                w_accept;

    assign w_accept = bus.st_valid && (r_state == S_IDLE);
    assign w_dec    = secded_decode(bus.cache_rd_data, bus.cache_rd_parity);

    always_comb begin
        w_merged = w_dec.data;
        for (int b = 0; b < 4; b++) begin
            if (r_be[b]) begin
                w_merged[8*b +: 8] = r_st_data[8*b +: 8];
            end
        end
    end

    // One encoder serves both the full-word path (IDLE) and the merged path (MERGE).
    assign w_enc_in = (r_state == S_MERGE) ? w_merged : bus.st_data;

    secded_encode u_encode (
        .data   (w_enc_in),
        .parity (w_enc_parity)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_st_data   <= '0;
            r_be        <= '0;
            r_wr_data   <= '0;
            r_wr_parity <= '0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= bus.st_addr;
                        r_st_data <= bus.st_data;
                        r_be      <= bus.st_be;
                        if (bus.st_be == 4'hF) begin
                            r_wr_data   <= bus.st_data;
                            r_wr_parity <= w_enc_parity;
                            r_wr_en     <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_WRITE;
                        end else if (bus.st_be == 4'h0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_MERGE;
                end
                S_MERGE: begin
                    if (w_dec.double_err) begin
                        r_done  <= 1'b1;
                        r_state <= S_ABORT;
                    end else begin
                        r_wr_data   <= w_merged;
                        r_wr_parity <= w_enc_parity;
                        r_wr_en     <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE, S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.st_ready        = (r_state == S_IDLE);
    assign bus.cache_rd_en     = r_rd_en;
    assign bus.cache_addr      = r_addr;
    assign bus.cache_wr_en     = r_wr_en;
    assign bus.cache_wr_data   = r_wr_data;
    assign bus.cache_wr_parity = r_wr_parity;
    assign bus.st_done         = r_done;
    // Error flags follow the old word, which is only present during MERGE.
    assign bus.single_error    = (r_state == S_MERGE) && w_dec.single_err;
    assign bus.DED_exception   = (r_state == S_MERGE) && w_dec.double_err;
endmodule
`default_nettype wire

// File: tb/tb_store_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_module
// Purpose  : Directed and randomized self-checking bench for store_module.
// Revision : 1.0
// ============================================================================
module tb_store_module;
    localparam int AW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_module_if #(.ADDR_W(AW)) bus();

    store_module #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem  [0:(1<<AW)-1];
    logic [6:0]  memp [0:(1<<AW)-1];
    logic [31:0] inj_d = '0;
    logic [6:0]  inj_p = '0;

    // Reference check bits built from an explicit 38-position codeword.
    function automatic logic [6:0] m_enc(input logic [31:0] d);
        logic       cw [1:38];
        logic [6:0] p;
        int         k;
        k = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ($countones(pos) == 1) begin
                cw[pos] = 1'b0;
            end else begin
                cw[pos] = d[k];
                k = k + 1;
            end
        end
        p = '0;
        for (int i = 0; i < 6; i++) begin
            for (int pos = 1; pos <= 38; pos++) begin
                if (((pos >> i) & 1) == 1) p[i] = p[i] ^ cw[pos];
            end
        end
        p[6] = (^d) ^ (^p[5:0]);
        return p;
    endfunction

    // Cache with one-cycle read latency and injectable bit flips.
    always @(posedge clk) begin
        if (bus.cache_rd_en) begin
            bus.cache_rd_data   <= mem[bus.cache_addr] ^ inj_d;
            bus.cache_rd_parity <= memp[bus.cache_addr] ^ inj_p;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [AW-1:0] a, input logic [31:0] d);
        mem[a]  = d;
        memp[a] = m_enc(d);
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic [31:0] fd, input logic [6:0] fp);
        logic [31:0] merged;
        logic [4:0]  exp;
        logic [4:0]  obs;
        int          nflips;
        bit          full, partial, writes, wr_now;
        nflips  = $countones(fd) + $countones(fp);
        full    = (be == 4'hF);
        partial = (be != 4'h0) && !full;
        writes  = full || (partial && nflips < 2);
        for (int b = 0; b < 4; b++) merged[8*b +: 8] = be[b] ? d[8*b +: 8] : mem[a][8*b +: 8];
        @(negedge clk);
        chk("ready_before", {63'd0, bus.st_ready}, 64'd1);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_be    = be;
        inj_d        = fd;
        inj_p        = fp;
        @(posedge clk);
        #1 bus.st_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            wr_now = (full && k == 1) || (partial && writes && k == 3);
            exp = {partial && k == 1, wr_now,
                   (be == 4'h0 && k == 1) || (full && k == 1) || (partial && k == 3),
                   partial && k == 2 && nflips == 1,
                   partial && k == 2 && nflips == 2};
            obs = {bus.cache_rd_en, bus.cache_wr_en, bus.st_done, bus.single_error, bus.DED_exception};
            chk($sformatf("strobes_cyc%0d_be%h_flips%0d", k, be, nflips), {59'd0, obs}, {59'd0, exp});
            if (partial && k == 1) chk("rd_addr", {54'd0, bus.cache_addr}, {54'd0, a});
            if (wr_now) begin
                chk("wr_addr", {54'd0, bus.cache_addr}, {54'd0, a});
                chk("wr_data", {32'd0, bus.cache_wr_data}, {32'd0, merged});
                chk("wr_parity", {57'd0, bus.cache_wr_parity}, {57'd0, m_enc(merged)});
            end
        end
        if (writes) set_word(a, merged);
        inj_d = '0;
        inj_p = '0;
    endtask

    initial begin
        logic [38:0] fm;
        int          nf, p0, p1;
        bus.st_valid        = 1'b0;
        bus.st_addr         = '0;
        bus.st_data         = '0;
        bus.st_be           = '0;
        bus.cache_rd_data   = '0;
        bus.cache_rd_parity = '0;
        for (int i = 0; i < (1 << AW); i++) set_word(i[AW-1:0], $urandom);

        repeat (3) @(negedge clk);
        chk("reset_strobes", {58'd0, bus.st_ready, bus.cache_rd_en, bus.cache_wr_en, bus.st_done,
                              bus.single_error, bus.DED_exception}, 64'h20);
        chk("reset_addr", {54'd0, bus.cache_addr}, 64'd0);
        chk("reset_wr_data", {32'd0, bus.cache_wr_data}, 64'd0);
        chk("reset_wr_parity", {57'd0, bus.cache_wr_parity}, 64'd0);
        rst_n = 1'b1;

        do_store(10'h010, 32'hDEADBEEF, 4'hF, 32'd0, 7'd0);
        set_word(10'h020, 32'h12345678);
        do_store(10'h020, 32'h000000AA, 4'b0001, 32'd0, 7'd0);
        chk("merge_result", {32'd0, mem[10'h020]}, 64'h123456AA);
        set_word(10'h020, 32'h12345678);
        do_store(10'h020, 32'h000000AA, 4'b0001, 32'h8, 7'd0);
        set_word(10'h020, 32'h12345678);
        do_store(10'h020, 32'h000000AA, 4'b0001, 32'h3, 7'd0);
        do_store(10'h030, 32'hCAFEF00D, 4'b0000, 32'd0, 7'd0);
        do_store(10'h031, 32'h0BADF00D, 4'b0110, 32'd0, 7'h04);

        // Reset pulled during READ drops the request.
        set_word(10'h055, 32'hA5A5A5A5);
        @(negedge clk);
        bus.st_valid = 1'b1;
        bus.st_addr  = 10'h055;
        bus.st_data  = 32'h11223344;
        bus.st_be    = 4'b0011;
        @(posedge clk);
        #1 bus.st_valid = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", {63'd0, bus.cache_rd_en}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {61'd0, bus.st_ready, bus.cache_rd_en, bus.st_done}, 64'h4);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {62'd0, bus.cache_wr_en, bus.st_done}, 64'd0);
        end
        do_store(10'h056, 32'h89ABCDEF, 4'hF, 32'd0, 7'd0);

        // Back-to-back full-word stores two cycles apart.
        @(negedge clk);
        bus.st_valid = 1'b1;
        bus.st_addr  = 10'h100;
        bus.st_data  = 32'h01020304;
        bus.st_be    = 4'hF;
        @(posedge clk);
        #1;
        bus.st_addr = 10'h101;
        bus.st_data = 32'hF0E0D0C0;
        @(negedge clk);
        chk("b2b_first", {30'd0, bus.cache_wr_en, bus.st_ready, bus.cache_wr_data}, {30'd0, 2'b10, 32'h01020304});
        @(negedge clk);
        chk("b2b_gap", {62'd0, bus.cache_wr_en, bus.st_ready}, 64'd1);
        @(posedge clk);
        #1 bus.st_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second", {30'd0, bus.cache_wr_en, bus.st_done, bus.cache_wr_data}, {30'd0, 2'b11, 32'hF0E0D0C0});
        set_word(10'h100, 32'h01020304);
        set_word(10'h101, 32'hF0E0D0C0);

        for (int t = 0; t < 40; t++) begin
            fm = '0;
            nf = int'($urandom_range(0, 2));
            p0 = int'($urandom_range(0, 38));
            p1 = (p0 + 1 + int'($urandom_range(0, 37))) % 39;
            if (nf >= 1) fm[p0] = 1'b1;
            if (nf == 2) fm[p1] = 1'b1;
            do_store(AW'($urandom_range(0, (1 << AW) - 1)), $urandom, 4'($urandom_range(0, 15)),
                     fm[31:0], fm[38:32]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
